computie_ad_target: RTL and testbench

Bus responder for Computie's narrow multiplexed address/data pin interface. It samples address and write-data beats from the shared AD pins, issues one access on a simple local register port, and returns read data by driving the AD pins back through the pin driver's output enable. It sits between the bidirectional AD pin driver (which owns the SB_IO primitives) and on-chip peripheral registers.

---
 rtl/computie_bus_pkg.sv | 29 ++
 rtl/computie_ad_target_if.sv | 22 ++
 rtl/computie_ad_shifter.sv | 57 +++++
 rtl/computie_ad_target.sv | 188 ++++++++++++++++++
 tb/tb_computie_ad_target.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/computie_bus_pkg.sv
// Shared definitions for the Computie multiplexed AD bus: responder states,
// active-low strobe constants and beat-count helpers.
package computie_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StReq,
    StTurn,
    StRdata,
    StDone,
    StAbort
  } ad_target_state_t;

  localparam logic AsAsserted    = 1'b0;
  localparam logic DtackAsserted = 1'b0;
  localparam logic DtackIdle     = 1'b1;

  function automatic int unsigned beat_count(int unsigned width, int unsigned ad_width);
    return width / ad_width;
  endfunction

  // Counter width able to hold 0..beats inclusive.
  function automatic int unsigned count_bits(int unsigned beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/computie_ad_target_if.sv
// Pin-side signals of the multiplexed AD bus, as seen by the initiator (master)
// and by the responder (slave).
interface computie_ad_target_if #(
  parameter int unsigned AD_WIDTH = 2
);
  logic                as_n;
  logic                rw;
  logic [AD_WIDTH-1:0] ad_in;
  logic [AD_WIDTH-1:0] ad_out;
  logic                ad_oe;
  logic                dtack_n;

  modport master (
    output as_n, rw, ad_in,
    input  ad_out, ad_oe, dtack_n
  );

  modport slave (
    input  as_n, rw, ad_in,
    output ad_out, ad_oe, dtack_n
  );
endinterface

// File: rtl/computie_ad_shifter.sv
// MSB-first beat shift register with a beat counter; shifts beats in from the
// pins, or parallel-loads a word and presents its top beat for shifting out.
module computie_ad_shifter
  import computie_bus_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AD_WIDTH = 2,
  localparam int unsigned Beats   = beat_count(WIDTH, AD_WIDTH),
  localparam int unsigned Cw      = count_bits(Beats)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                shift_i,
  input  logic                load_i,
  input  logic [AD_WIDTH-1:0] beat_i,
  input  logic [WIDTH-1:0]    load_data_i,
  output logic [WIDTH-1:0]    data_o,
  output logic [AD_WIDTH-1:0] beat_o,
  output logic [Cw-1:0]       count_o
);

  logic [WIDTH-1:0]          data_q, data_d;
  logic [Cw-1:0]             count_q, count_d;
  logic [WIDTH+AD_WIDTH-1:0] shifted;

  always_comb begin
    shifted = {data_q, beat_i};
    data_d  = data_q;
    count_d = count_q;
    if (load_i) begin
      data_d  = load_data_i;
      count_d = '0;
    end else begin
      if (shift_i) begin
        data_d = shifted[WIDTH-1:0];
      end
      // start_i restarts the count, so the first beat of a field counts as 1.
      count_d = (start_i ? '0 : count_q) + Cw'(shift_i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign beat_o  = data_q[WIDTH-1 -: AD_WIDTH];
  assign count_o = count_q;

endmodule

// File: rtl/computie_ad_target.sv
// Responder for the Computie multiplexed AD bus: collects address/write-data
// beats, runs one local register access, and drives read data back on the pins.
module computie_ad_target
  import computie_bus_pkg::*;
#(
  parameter int unsigned AD_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  computie_ad_target_if.slave    bus,
  output logic                   req,
  output logic                   we,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [DATA_WIDTH-1:0]  wdata,
  input  logic [DATA_WIDTH-1:0]  rdata,
  input  logic                   ack
);

  localparam int unsigned AddrBeats = beat_count(ADDR_WIDTH, AD_WIDTH);
  localparam int unsigned DataBeats = beat_count(DATA_WIDTH, AD_WIDTH);
  localparam int unsigned Acw       = count_bits(AddrBeats);
  localparam int unsigned Dcw       = count_bits(DataBeats);

  ad_target_state_t      state_q, state_d;
  logic                  we_q, we_d;
  logic                  ad_oe_q, ad_oe_d;
  logic [AD_WIDTH-1:0]   ad_out_q, ad_out_d;
  logic                  dtack_n_q, dtack_n_d;
  logic                  disarmed_q, disarmed_d;

  logic                  as_low;
  logic                  a_start, a_shift;
  logic                  d_start, d_shift, d_load;
  logic [Acw-1:0]        addr_cnt;
  logic [Dcw-1:0]        data_cnt;
  logic [AD_WIDTH-1:0]   data_beat;
  logic [AD_WIDTH-1:0]   addr_beat_unused;

  computie_ad_shifter #(
    .WIDTH    (ADDR_WIDTH),
    .AD_WIDTH (AD_WIDTH)
  ) u_addr_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (a_start),
    .shift_i     (a_shift),
    .load_i      (1'b0),
    .beat_i      (bus.ad_in),
    .load_data_i ('0),
    .data_o      (addr),
    .beat_o      (addr_beat_unused),
    .count_o     (addr_cnt)
  );

  // Shared by write data (shift in) and read data (load, then shift out).
  computie_ad_shifter #(
    .WIDTH    (DATA_WIDTH),
    .AD_WIDTH (AD_WIDTH)
  ) u_data_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (d_start),
    .shift_i     (d_shift),
    .load_i      (d_load),
    .beat_i      (bus.ad_in),
    .load_data_i (rdata),
    .data_o      (wdata),
    .beat_o      (data_beat),
    .count_o     (data_cnt)
  );

  always_comb begin
    as_low    = (bus.as_n == AsAsserted);
    state_d   = state_q;
    we_d      = we_q;
    ad_oe_d   = 1'b0;
    ad_out_d  = ad_out_q;
    dtack_n_d = DtackIdle;
    a_start   = (state_q == StIdle);
    a_shift   = 1'b0;
    d_start   = (state_q == StIdle) || (state_q == StAddr);
    d_shift   = 1'b0;
    d_load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (as_low && !disarmed_q) begin
          a_shift = 1'b1;
          we_d    = ~bus.rw;
          state_d = (AddrBeats == 1) ? (bus.rw ? StReq : StWdata) : StAddr;
        end
      end
      StAddr: begin
        if (!as_low) begin
          state_d = StIdle;
        end else begin
          a_shift = 1'b1;
          if (addr_cnt == Acw'(AddrBeats - 1)) state_d = we_q ? StWdata : StReq;
        end
      end
      StWdata: begin
        if (!as_low) begin
          state_d = StIdle;
        end else begin
          d_shift = 1'b1;
          if (data_cnt == Dcw'(DataBeats - 1)) state_d = StReq;
        end
      end
      StReq: begin
        if (ack) begin
          if (!as_low) begin
            state_d = StIdle;
          end else if (we_q) begin
            state_d   = StDone;
            dtack_n_d = DtackAsserted;
          end else begin
            d_load  = 1'b1;
            state_d = StTurn;
          end
        end else if (!as_low) begin
          state_d = StAbort;
        end
      end
      StTurn: begin
        if (!as_low) begin
          state_d = StIdle;
        end else begin
          d_shift  = 1'b1;
          ad_oe_d  = 1'b1;
          ad_out_d = data_beat;
          state_d  = StRdata;
        end
      end
      StRdata: begin
        if (!as_low) begin
          state_d = StIdle;
        end else if (data_cnt != Dcw'(DataBeats)) begin
          d_shift  = 1'b1;
          ad_oe_d  = 1'b1;
          ad_out_d = data_beat;
        end else begin
          state_d   = StDone;
          dtack_n_d = DtackAsserted;
        end
      end
      StDone: begin
        if (!as_low) state_d = StIdle;
        else         dtack_n_d = DtackAsserted;
      end
      StAbort: begin
        if (ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A strobe still held low after a transaction must not start another one.
    if (!as_low)                disarmed_d = 1'b0;
    else if (state_q != StIdle) disarmed_d = 1'b1;
    else                        disarmed_d = disarmed_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= '0;
      dtack_n_q  <= DtackIdle;
      disarmed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      ad_oe_q    <= ad_oe_d;
      ad_out_q   <= ad_out_d;
      dtack_n_q  <= dtack_n_d;
      disarmed_q <= disarmed_d;
    end
  end

  assign req         = (state_q == StReq) || (state_q == StAbort);
  assign we          = we_q;
  assign bus.ad_oe   = ad_oe_q;
  assign bus.ad_out  = ad_out_q;
  assign bus.dtack_n = dtack_n_q;

endmodule

// File: tb/tb_computie_ad_target.sv
// Bench for computie_ad_target: acts as bus initiator and as the local
// register file (byte array), checking pin and local-port timing per cycle.
module tb_computie_ad_target;

  logic       clk;
  logic       reset_n;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  mem [256];

  computie_ad_target_if #(.AD_WIDTH(2)) bus_if ();

  computie_ad_target #(
    .AD_WIDTH   (2),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat i of an 8-bit value, MSB first.
  function automatic logic [1:0] beat_of(input logic [7:0] v, input int i);
    logic [7:0] t;
    t = v >> (6 - 2 * i);
    return t[1:0];
  endfunction

  task automatic send_addr(input logic [7:0] a, input logic is_read);
    bus_if.as_n = 1'b0;
    bus_if.rw   = is_read;
    for (int i = 0; i < 4; i++) begin
      bus_if.ad_in = beat_of(a, i);
      step();
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int delay,
                          input int hold);
    send_addr(a, 1'b0);
    check("wr_no_req_in_data", 32'(req), 32'(0));
    for (int i = 0; i < 4; i++) begin
      bus_if.ad_in = beat_of(d, i);
      step();
    end
    check("wr_req", 32'(req), 32'(1));
    check("wr_we", 32'(we), 32'(1));
    check("wr_addr", 32'(addr), 32'(a));
    check("wr_wdata", 32'(wdata), 32'(d));
    for (int c = 0; c < delay; c++) begin
      check("wr_dtack_early", 32'(bus_if.dtack_n), 32'(1));
      step();
      check("wr_req_held", 32'(req), 32'(1));
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    mem[a] = d;
    check("wr_dtack", 32'(bus_if.dtack_n), 32'(0));
    check("wr_req_drop", 32'(req), 32'(0));
    check("wr_oe", 32'(bus_if.ad_oe), 32'(0));
    for (int c = 0; c < hold; c++) begin
      step();
      check("hold_dtack", 32'(bus_if.dtack_n), 32'(0));
      check("hold_no_req", 32'(req), 32'(0));
    end
    bus_if.as_n = 1'b1;
    step();
    check("wr_dtack_release", 32'(bus_if.dtack_n), 32'(1));
  endtask

  task automatic do_read(input logic [7:0] a, input int delay, input int hold);
    logic [7:0] exp;
    exp = mem[a];
    send_addr(a, 1'b1);
    check("rd_req", 32'(req), 32'(1));
    check("rd_we", 32'(we), 32'(0));
    check("rd_addr", 32'(addr), 32'(a));
    for (int c = 0; c < delay; c++) begin
      step();
      check("rd_req_held", 32'(req), 32'(1));
    end
    rdata = exp;
    ack   = 1'b1;
    step();
    ack   = 1'b0;
    rdata = 8'($urandom);
    check("rd_turn_oe", 32'(bus_if.ad_oe), 32'(0));
    check("rd_req_drop", 32'(req), 32'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      check("rd_oe", 32'(bus_if.ad_oe), 32'(1));
      check("rd_beat", 32'(bus_if.ad_out), 32'(beat_of(exp, i)));
      check("rd_dtack_early", 32'(bus_if.dtack_n), 32'(1));
    end
    step();
    check("rd_dtack", 32'(bus_if.dtack_n), 32'(0));
    check("rd_oe_drop", 32'(bus_if.ad_oe), 32'(0));
    for (int c = 0; c < hold; c++) begin
      step();
      check("rd_hold_no_req", 32'(req), 32'(0));
    end
    bus_if.as_n = 1'b1;
    step();
    check("rd_dtack_release", 32'(bus_if.dtack_n), 32'(1));
  endtask

  initial begin
    logic [7:0] ra;
    reset_n      = 1'b0;
    bus_if.as_n  = 1'b1;
    bus_if.rw    = 1'b0;
    bus_if.ad_in = '0;
    ack          = 1'b0;
    rdata        = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    step();
    step();
    check("rst_oe", 32'(bus_if.ad_oe), 32'(0));
    check("rst_out", 32'(bus_if.ad_out), 32'(0));
    check("rst_dtack", 32'(bus_if.dtack_n), 32'(1));
    check("rst_req", 32'(req), 32'(0));
    check("rst_we", 32'(we), 32'(0));
    check("rst_addr", 32'(addr), 32'(0));
    check("rst_wdata", 32'(wdata), 32'(0));
    reset_n = 1'b1;
    step();

    // Directed write and read from the example transactions.
    do_write(8'h3C, 8'hA5, 3, 0);
    mem[8'h81] = 8'h6E;
    do_read(8'h81, 1, 0);

    // Abort after three address beats.
    bus_if.as_n = 1'b0;
    bus_if.rw   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_if.ad_in = 2'(i);
      step();
    end
    bus_if.as_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("abort_addr_req", 32'(req), 32'(0));
      check("abort_addr_dtack", 32'(bus_if.dtack_n), 32'(1));
    end

    // Abort while the local access is pending.
    send_addr(8'h55, 1'b1);
    check("abort_req_pending", 32'(req), 32'(1));
    bus_if.as_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("abort_req_held", 32'(req), 32'(1));
      check("abort_req_oe", 32'(bus_if.ad_oe), 32'(0));
      check("abort_req_dtack", 32'(bus_if.dtack_n), 32'(1));
    end
    rdata = 8'hFF;
    ack   = 1'b1;
    step();
    ack   = 1'b0;
    check("abort_req_drop", 32'(req), 32'(0));
    for (int c = 0; c < 2; c++) begin
      step();
      check("abort_idle_req", 32'(req), 32'(0));
      check("abort_idle_oe", 32'(bus_if.ad_oe), 32'(0));
      check("abort_idle_dtack", 32'(bus_if.dtack_n), 32'(1));
    end

    // Strobe held low after DONE, then a fresh transaction after one high cycle.
    do_write(8'($urandom), 8'($urandom), 1, 5);
    do_write(8'h81, 8'h17, 0, 0);
    do_read(8'h81, 0, 0);

    // Randomized traffic against the byte-array model.
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom);
      if ($urandom_range(1, 0) == 1) do_read(ra, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
      else do_write(ra, 8'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
    end

    // Reset asserted while read beat 1 is on the pins.
    ra = 8'($urandom);
    send_addr(ra, 1'b1);
    rdata = mem[ra];
    ack   = 1'b1;
    step();
    ack   = 1'b0;
    step();
    step();
    check("pre_rst_oe", 32'(bus_if.ad_oe), 32'(1));
    check("pre_rst_beat1", 32'(bus_if.ad_out), 32'(beat_of(mem[ra], 1)));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(bus_if.ad_oe), 32'(0));
    check("mid_rst_req", 32'(req), 32'(0));
    check("mid_rst_out", 32'(bus_if.ad_out), 32'(0));
    check("mid_rst_dtack", 32'(bus_if.dtack_n), 32'(1));
    check("mid_rst_addr", 32'(addr), 32'(0));
    check("mid_rst_wdata", 32'(wdata), 32'(0));
    check("mid_rst_we", 32'(we), 32'(0));
    bus_if.as_n = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    do_write(8'h42, 8'hC3, 2, 0);
    do_read(8'h42, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
